// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, oversampling constants,
// baud_select names and the baud-rate divisor table (50 MHz system clock).
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   localparam int unsigned SAMPLES_PER_BIT = 16;
   localparam int unsigned MID_SAMPLE      = 7;

   localparam logic [2:0] BAUD_300    = 3'b000;
   localparam logic [2:0] BAUD_1200   = 3'b001;
   localparam logic [2:0] BAUD_4800   = 3'b010;
   localparam logic [2:0] BAUD_9600   = 3'b011;
   localparam logic [2:0] BAUD_19200  = 3'b100;
   localparam logic [2:0] BAUD_38400  = 3'b101;
   localparam logic [2:0] BAUD_57600  = 3'b110;
   localparam logic [2:0] BAUD_115200 = 3'b111;

   // Clocks per oversampling tick: round(50e6 / (16 * baud)).
   function automatic logic [13:0] baud_divisor(input logic [2:0] sel);
      case (sel)
         BAUD_300:    return 14'd10417;
         BAUD_1200:   return 14'd2604;
         BAUD_4800:   return 14'd651;
         BAUD_9600:   return 14'd326;
         BAUD_19200:  return 14'd163;
         BAUD_38400:  return 14'd81;
         BAUD_57600:  return 14'd54;
         default:     return 14'd27;
      endcase
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side UART bus: rate/enable/line inputs and byte/status outputs.
interface uart_receiver_if;
   import uart_pkg::*;

   logic [2:0] baud_select;
   logic       Rx_EN;
   logic       RxD;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID;
   logic       Rx_PERROR;
   logic       Rx_FERROR;
   logic       Rx_BUSY;

   modport master (
      output baud_select, Rx_EN, RxD,
      input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
   );

   modport slave (
      input  baud_select, Rx_EN, RxD,
      output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY
   );

endinterface

// File: rtl/uart_receiver_baud_controller.sv
// baud_controller: free-running divider producing a one-clock enable at
// 16x the selected baud rate.
module baud_controller
   import uart_pkg::*;
(
   input  logic       reset,
   input  logic       clk,
   input  logic [2:0] baud_select,
   output logic       sample_ENABLE
);

   logic [13:0] cnt_q, cnt_d;
   logic [13:0] div;
   logic        tick;

   assign div  = baud_divisor(baud_select);
   // >= so a rate change to a shorter period never lets the counter run away.
   assign tick = (cnt_q >= (div - 14'd1));
   assign sample_ENABLE = tick;

   always_comb begin
      cnt_d = cnt_q + 14'd1;
      if (tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_receiver.sv
// 8E1 UART receiver with 16x oversampling. Define RX_MAJORITY_VOTE_EN for a
// 2-of-3 vote over samples 6/7/8 instead of a single mid-bit sample.
module uart_receiver
   import uart_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   uart_receiver_if.slave  bus
);

   localparam logic [3:0] LAST_CNT = 4'(SAMPLES_PER_BIT - 1);

   logic       Rx_sample_ENABLE;
   logic [1:0] sync_q;
   logic       rxd_s, rxd_prev_q;
   logic       bit_val;

   rx_state_e  state_q, state_d;
   logic [3:0] sample_q, sample_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       perr_q, perr_d;
   logic       ferr_q, ferr_d;

   baud_controller baud_controller_rx_inst (
      .reset         (reset),
      .clk           (clk),
      .baud_select   (bus.baud_select),
      .sample_ENABLE (Rx_sample_ENABLE)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[0], bus.RxD};
         rxd_prev_q <= rxd_s;
      end
   end
   assign rxd_s = sync_q[1];

`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE + 1);
   logic s6_q, s7_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s6_q <= 1'b0;
         s7_q <= 1'b0;
      end else if (Rx_sample_ENABLE && state_q != RX_IDLE) begin
         if (sample_q == DECIDE_CNT - 4'd2) s6_q <= rxd_s;
         if (sample_q == DECIDE_CNT - 4'd1) s7_q <= rxd_s;
      end
   end
   assign bit_val = (s6_q & s7_q) | (s6_q & rxd_s) | (s7_q & rxd_s);
`else
   localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE);
   assign bit_val = rxd_s;
`endif

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      perr_d   = perr_q;
      ferr_d   = ferr_q;

      if (state_q != RX_IDLE && Rx_sample_ENABLE) sample_d = sample_q + 4'd1;

      if (!bus.Rx_EN) begin
         state_d = RX_IDLE;
      end else begin
         case (state_q)
            RX_IDLE: begin
               if (rxd_prev_q && !rxd_s) begin
                  sample_d = '0;
                  bit_d    = '0;
                  perr_d   = 1'b0;
                  ferr_d   = 1'b0;
                  state_d  = RX_START;
               end
            end
            RX_START: begin
               if (Rx_sample_ENABLE) begin
                  if (sample_q == DECIDE_CNT && bit_val) state_d = RX_IDLE;
                  else if (sample_q == LAST_CNT)         state_d = RX_DATA;
               end
            end
            RX_DATA: begin
               if (Rx_sample_ENABLE) begin
                  if (sample_q == DECIDE_CNT) shift_d[bit_q] = bit_val;
                  if (sample_q == LAST_CNT) begin
                     bit_d = bit_q + 3'd1;
                     if (bit_q == 3'd7) state_d = RX_PARITY;
                  end
               end
            end
            RX_PARITY: begin
               if (Rx_sample_ENABLE) begin
                  if (sample_q == DECIDE_CNT) par_d = bit_val;
                  if (sample_q == LAST_CNT)   state_d = RX_STOP;
               end
            end
            RX_STOP: begin
               // Completes half a bit early so a back-to-back start edge is seen.
               if (Rx_sample_ENABLE && sample_q == DECIDE_CNT) begin
                  data_d  = shift_q;
                  ferr_d  = !bit_val;
                  perr_d  = ((^shift_q) != par_q);
                  valid_d = bit_val && ((^shift_q) == par_q);
                  state_d = RX_IDLE;
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RX_IDLE;
         sample_q <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
      end
   end

   assign bus.Rx_DATA   = data_q;
   assign bus.Rx_VALID  = valid_q;
   assign bus.Rx_PERROR = perr_q;
   assign bus.Rx_FERROR = ferr_q;
   assign bus.Rx_BUSY   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed, table-driven bench for uart_receiver at 115200 baud (27 clk/tick).
module tb_uart_receiver;

   localparam int BIT_CLKS = 432;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stp;
      logic [7:0] exp_data;
      int         exp_valid;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_receiver_if bus();

   uart_receiver dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   int         valid_cnt = 0;
   int         long_pulse = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] got_q[$];

   always @(negedge clk) begin
      if (bus.Rx_VALID) begin
         valid_cnt++;
         got_q.push_back(bus.Rx_DATA);
         if (prev_valid) long_pulse++;
      end
      prev_valid = bus.Rx_VALID;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first nbits of {stop, parity, data, start}; glitch_pos inverts
   // the line for one tick around the middle of that frame bit.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int nbits, input int glitch_pos);
      logic [10:0] frame;
      frame = {stp, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.RxD = frame[i];
         if (i == glitch_pos) begin
            wait_clks(195);
            bus.RxD = ~frame[i];
            wait_clks(27);
            bus.RxD = frame[i];
            wait_clks(BIT_CLKS - 222);
         end else begin
            wait_clks(BIT_CLKS);
         end
      end
      bus.RxD = 1'b1;
   endtask

   vec_t vecs[6];
   int   v0;

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
      vecs[1] = '{8'h07, 1'b0, 1'b1, 8'h07, 0, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 0, 1'b0, 1'b1};
      vecs[3] = '{8'h11, 1'b0, 1'b1, 8'h11, 1, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1, 1'b0, 1'b0};
      vecs[5] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 0, 1'b1, 1'b1};

      @(negedge clk);
      reset = 1'b1;
      bus.baud_select = 3'b111;
      bus.Rx_EN = 1'b1;
      bus.RxD = 1'b1;
      wait_clks(5);
      check("rst_data",  {24'd0, bus.Rx_DATA}, 32'h00);
      check("rst_valid", {31'd0, bus.Rx_VALID}, 32'd0);
      check("rst_perr",  {31'd0, bus.Rx_PERROR}, 32'd0);
      check("rst_ferr",  {31'd0, bus.Rx_FERROR}, 32'd0);
      check("rst_busy",  {31'd0, bus.Rx_BUSY}, 32'd0);
      reset = 1'b0;
      wait_clks(BIT_CLKS);

      for (int i = 0; i < 6; i++) begin
         v0 = valid_cnt;
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stp, 11, -1);
         wait_clks(2 * BIT_CLKS);
         check($sformatf("vec%0d_data", i), {24'd0, bus.Rx_DATA}, {24'd0, vecs[i].exp_data});
         check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
         check($sformatf("vec%0d_perr", i), {31'd0, bus.Rx_PERROR}, {31'd0, vecs[i].exp_perr});
         check($sformatf("vec%0d_ferr", i), {31'd0, bus.Rx_FERROR}, {31'd0, vecs[i].exp_ferr});
         check($sformatf("vec%0d_busy", i), {31'd0, bus.Rx_BUSY}, 32'd0);
      end

      // False start: low for 4 ticks; the accepted edge still clears old flags.
      v0 = valid_cnt;
      bus.RxD = 1'b0;
      wait_clks(50);
      check("fs_busy_hi", {31'd0, bus.Rx_BUSY}, 32'd1);
      wait_clks(58);
      bus.RxD = 1'b1;
      wait_clks(2 * BIT_CLKS);
      check("fs_busy_lo", {31'd0, bus.Rx_BUSY}, 32'd0);
      check("fs_valid",   valid_cnt - v0, 32'd0);
      check("fs_perr",    {31'd0, bus.Rx_PERROR}, 32'd0);
      check("fs_ferr",    {31'd0, bus.Rx_FERROR}, 32'd0);
      check("fs_data",    {24'd0, bus.Rx_DATA}, 32'hC3);

      // Back-to-back frames with no idle gap.
      v0 = valid_cnt;
      send_frame(8'h00, 1'b0, 1'b1, 11, -1);
      send_frame(8'hFF, 1'b0, 1'b1, 11, -1);
      wait_clks(2 * BIT_CLKS);
      check("b2b_valid", valid_cnt - v0, 32'd2);
      if (got_q.size() >= 2) begin
         check("b2b_first",  {24'd0, got_q[got_q.size()-2]}, 32'h00);
         check("b2b_second", {24'd0, got_q[got_q.size()-1]}, 32'hFF);
      end else begin
         check("b2b_queue", got_q.size(), 32'd2);
      end

      // Rx_EN dropped mid-frame aborts without touching outputs.
      v0 = valid_cnt;
      send_frame(8'h33, 1'b0, 1'b1, 5, -1);
      bus.Rx_EN = 1'b0;
      wait_clks(2);
      check("abort_busy", {31'd0, bus.Rx_BUSY}, 32'd0);
      wait_clks(7 * BIT_CLKS);
      bus.Rx_EN = 1'b1;
      wait_clks(BIT_CLKS);
      check("abort_valid", valid_cnt - v0, 32'd0);
      check("abort_data",  {24'd0, bus.Rx_DATA}, 32'hFF);
      check("abort_perr",  {31'd0, bus.Rx_PERROR}, 32'd0);
      check("abort_ferr",  {31'd0, bus.Rx_FERROR}, 32'd0);

      // Reset after data bit 4, then a clean 0x5A.
      v0 = valid_cnt;
      send_frame(8'h5A, 1'b0, 1'b1, 6, -1);
      reset = 1'b1;
      wait_clks(3);
      reset = 1'b0;
      wait_clks(1);
      check("mrst_data",  {24'd0, bus.Rx_DATA}, 32'h00);
      check("mrst_valid", valid_cnt - v0, 32'd0);
      check("mrst_perr",  {31'd0, bus.Rx_PERROR}, 32'd0);
      check("mrst_ferr",  {31'd0, bus.Rx_FERROR}, 32'd0);
      check("mrst_busy",  {31'd0, bus.Rx_BUSY}, 32'd0);
      wait_clks(BIT_CLKS);
      v0 = valid_cnt;
      send_frame(8'h5A, 1'b0, 1'b1, 11, -1);
      wait_clks(2 * BIT_CLKS);
      check("post_data",  {24'd0, bus.Rx_DATA}, 32'h5A);
      check("post_valid", valid_cnt - v0, 32'd1);
      check("post_perr",  {31'd0, bus.Rx_PERROR}, 32'd0);
      check("post_ferr",  {31'd0, bus.Rx_FERROR}, 32'd0);

`ifdef RX_MAJORITY_VOTE_EN
      v0 = valid_cnt;
      send_frame(8'h5A, 1'b0, 1'b1, 11, 3);
      wait_clks(2 * BIT_CLKS);
      check("glitch_data",  {24'd0, bus.Rx_DATA}, 32'h5A);
      check("glitch_valid", valid_cnt - v0, 32'd1);
`endif

      check("pulse_width", long_pulse, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
